// File: rtl/uart_packet_deframer.sv
// UART packet deframer: turns a byte stream of SYNC, Destination, Source,
// Length and Length payload bytes into a registered packet beat stream.
// An inter-byte timeout abandons a stalled packet and pulses opError.

package uart_packet_pkg;

    typedef struct packed {
        logic [7:0] source;
        logic [7:0] destination;
        logic [7:0] length;
        logic       sop;
        logic       eop;
        logic [7:0] data;
        logic       valid;
    } uart_packet_t;

endpackage

module uart_packet_deframer
    import uart_packet_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         TIMEOUT_CYCLES = 5000
) (
    input  logic         ipClk,
    input  logic         ipReset,
    input  logic [7:0]   ipRxData,
    input  logic         ipRxValid,
    output uart_packet_t opRxStream,
    output logic         opError
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // The abort fires on the cycle the counter would step onto TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DEST = 3'd1;
    localparam logic [2:0] ST_SRC  = 3'd2;
    localparam logic [2:0] ST_LEN  = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [7:0]       dest_q,   dest_d;
    logic [7:0]       src_q,    src_d;
    logic [7:0]       len_q,    len_d;
    logic [7:0]       remain_q, remain_d;
    logic [CNT_W-1:0] tmo_q,    tmo_d;
    uart_packet_t     out_q,    out_d;
    logic             error_q,  error_d;

    // Next-state logic: a received byte always wins over the timeout abort.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        src_d     = src_q;
        len_d     = len_q;
        remain_d  = remain_q;
        tmo_d     = tmo_q;
        out_d     = out_q;
        out_d.valid = 1'b0;
        error_d   = 1'b0;

        if (ipRxValid) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (ipRxData == SYNC_BYTE) begin
                        state_d = ST_DEST;
                    end
                end
                ST_DEST: begin
                    dest_d  = ipRxData;
                    state_d = ST_SRC;
                end
                ST_SRC: begin
                    src_d   = ipRxData;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    len_d    = ipRxData;
                    remain_d = ipRxData;
                    state_d  = (ipRxData == 8'd0) ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    out_d.source      = src_q;
                    out_d.destination = dest_q;
                    out_d.length      = len_q;
                    out_d.sop         = (remain_q == len_q);
                    out_d.eop         = (remain_q == 8'd1);
                    out_d.data        = ipRxData;
                    out_d.valid       = 1'b1;
                    remain_d          = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TIMEOUT_LAST) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
            error_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // State and output registers, cleared immediately by the active-low reset.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q  <= ST_IDLE;
            dest_q   <= '0;
            src_q    <= '0;
            len_q    <= '0;
            remain_q <= '0;
            tmo_q    <= '0;
            out_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            src_q    <= src_d;
            len_q    <= len_d;
            remain_q <= remain_d;
            tmo_q    <= tmo_d;
            out_q    <= out_d;
            error_q  <= error_d;
        end
    end

    assign opRxStream = out_q;
    assign opError    = error_q;

endmodule

// File: tb/tb_uart_packet_deframer.sv
// Bench for uart_packet_deframer: expected beats go into a scoreboard queue
// as bytes are driven, and a negedge monitor pops and compares every beat.

module tb_uart_packet_deframer;
    import uart_packet_pkg::*;

    localparam int TMO = 20;

    typedef struct {
        uart_packet_t beat;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    uart_packet_t rx_stream;
    logic         rx_error;

    int   checks_total  = 0;
    int   checks_passed = 0;
    int   cyc           = 0;
    int   err_count     = 0;
    int   last_err_cyc  = -1;
    logic prev_err      = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    uart_packet_deframer #(
        .SYNC_BYTE      (8'h55),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ipClk      (clk),
        .ipReset    (rst_n),
        .ipRxData   (rx_data),
        .ipRxValid  (rx_valid),
        .opRxStream (rx_stream),
        .opError    (rx_error)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to check beat latency and error timing.
    always @(posedge clk) cyc++;

    // Scoreboard monitor: every beat must match the head of the queue in
    // content and cycle; opError must never last two cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_stream.valid) begin
                checks_total++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL unexpected_beat got %h at cycle %0d, queue empty", rx_stream, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (rx_stream !== mon_e.beat || cyc != mon_e.cyc)
                        $display("[TB] FAIL beat got %h at cycle %0d expected %h at cycle %0d",
                                 rx_stream, cyc, mon_e.beat, mon_e.cyc);
                    else
                        checks_passed++;
                end
            end
            if (rx_error) begin
                err_count++;
                last_err_cyc = cyc;
                checks_total++;
                if (prev_err)
                    $display("[TB] FAIL error_width opError high on consecutive cycles at %0d", cyc);
                else
                    checks_passed++;
            end
            prev_err = rx_error;
        end
    end

    // Global time limit so the bench never hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish, %0d/%0d passed", checks_passed, checks_total);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, output int drive_cyc);
        @(negedge clk);
        rx_data   = b;
        rx_valid  = 1'b1;
        drive_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'h00;
        end
    endtask

    task automatic push_beat(input logic [7:0] dest, input logic [7:0] src, input logic [7:0] len,
                             input logic sop, input logic eop, input logic [7:0] data, input int c);
        exp_t e;
        e.beat.source      = src;
        e.beat.destination = dest;
        e.beat.length      = len;
        e.beat.sop         = sop;
        e.beat.eop         = eop;
        e.beat.data        = data;
        e.beat.valid       = 1'b1;
        e.cyc              = c + 1;
        sb.push_back(e);
    endtask

    // Sends a full packet whose payload is base, base+step, ... and queues its beats.
    task automatic send_packet(input logic [7:0] dest, input logic [7:0] src, input int len,
                               input logic [7:0] base, input int step);
        int c;
        logic [7:0] d;
        send_byte(8'h55, c);
        send_byte(dest, c);
        send_byte(src, c);
        send_byte(8'(len), c);
        for (int i = 0; i < len; i++) begin
            d = 8'(int'(base) + i * step);
            send_byte(d, c);
            push_beat(dest, src, 8'(len), i == 0, i == len - 1, d, c);
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        checks_total++;
        if (rx_stream !== '0) $display("[TB] FAIL reset_stream got %h expected 0", rx_stream);
        else checks_passed++;
        checks_total++;
        if (rx_error !== 1'b0) $display("[TB] FAIL reset_error got %b expected 0", rx_error);
        else checks_passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks_total++;
        if (rx_stream.valid !== 1'b0) $display("[TB] FAIL reset_release_valid got %b expected 0", rx_stream.valid);
        else checks_passed++;
    endtask

    task automatic test_basic;
        uart_packet_t hold;
        send_packet(8'h01, 8'hAA, 5, 8'h12, 5);
        idle(3);
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL basic_drain got %0d pending expected 0", sb.size());
        else checks_passed++;
        hold = '{source: 8'hAA, destination: 8'h01, length: 8'h05, sop: 1'b0, eop: 1'b1,
                 data: 8'h26, valid: 1'b0};
        checks_total++;
        if (rx_stream !== hold) $display("[TB] FAIL basic_hold got %h expected %h", rx_stream, hold);
        else checks_passed++;
    endtask

    task automatic test_garbage;
        int c;
        send_byte(8'h00, c);
        send_byte(8'hFF, c);
        send_packet(8'h00, 8'hAA, 1, 8'h12, 0);
        idle(3);
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL garbage_drain got %0d pending expected 0", sb.size());
        else checks_passed++;
    endtask

    task automatic test_zero_length;
        int c;
        send_byte(8'h55, c);
        send_byte(8'h00, c);
        send_byte(8'hAA, c);
        send_byte(8'h00, c);
        idle(2);
        send_packet(8'h02, 8'hAA, 1, 8'h34, 0);
        idle(3);
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL zero_len_drain got %0d pending expected 0", sb.size());
        else checks_passed++;
    endtask

    task automatic test_back_to_back;
        send_packet(8'h03, 8'h44, 255, 8'h00, 1);
        send_packet(8'h07, 8'h08, 2, 8'h55, 0);
        idle(3);
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL back_to_back_drain got %0d pending expected 0", sb.size());
        else checks_passed++;
    endtask

    task automatic test_timeout;
        int c;
        int e0;
        e0 = err_count;
        send_byte(8'h55, c);
        send_byte(8'h01, c);
        send_byte(8'hAA, c);
        send_byte(8'h03, c);
        send_byte(8'h12, c);
        push_beat(8'h01, 8'hAA, 8'h03, 1'b1, 1'b0, 8'h12, c);
        idle(TMO + 3);
        checks_total++;
        if (err_count - e0 != 1) $display("[TB] FAIL timeout_count got %0d pulses expected 1", err_count - e0);
        else checks_passed++;
        checks_total++;
        if (last_err_cyc != c + 1 + TMO)
            $display("[TB] FAIL timeout_cycle got %0d expected %0d", last_err_cyc, c + 1 + TMO);
        else checks_passed++;
        send_packet(8'h09, 8'h0A, 2, 8'hC0, 3);
        idle(3);
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL timeout_drain got %0d pending expected 0", sb.size());
        else checks_passed++;
    endtask

    task automatic test_timeout_boundary;
        int c;
        int e0;
        e0 = err_count;
        send_byte(8'h55, c);
        send_byte(8'h01, c);
        send_byte(8'hAA, c);
        send_byte(8'h02, c);
        send_byte(8'h12, c);
        push_beat(8'h01, 8'hAA, 8'h02, 1'b1, 1'b0, 8'h12, c);
        idle(TMO - 1);
        send_byte(8'h34, c);
        push_beat(8'h01, 8'hAA, 8'h02, 1'b0, 1'b1, 8'h34, c);
        idle(TMO + 3);
        checks_total++;
        if (err_count != e0) $display("[TB] FAIL boundary_error got %0d pulses expected 0", err_count - e0);
        else checks_passed++;
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL boundary_drain got %0d pending expected 0", sb.size());
        else checks_passed++;
    endtask

    task automatic test_reset_mid_packet;
        int c;
        send_byte(8'h55, c);
        send_byte(8'h01, c);
        send_byte(8'hAA, c);
        send_byte(8'h05, c);
        send_byte(8'h12, c);
        push_beat(8'h01, 8'hAA, 8'h05, 1'b1, 1'b0, 8'h12, c);
        send_byte(8'h34, c);
        push_beat(8'h01, 8'hAA, 8'h05, 1'b0, 1'b0, 8'h34, c);
        idle(1);
        #3;
        rst_n = 1'b0;
        #1;
        checks_total++;
        if (rx_stream !== '0 || rx_error !== 1'b0)
            $display("[TB] FAIL mid_reset_async got %h/%b expected 0/0", rx_stream, rx_error);
        else checks_passed++;
        repeat (3) @(negedge clk);
        checks_total++;
        if (rx_stream !== '0) $display("[TB] FAIL mid_reset_hold got %h expected 0", rx_stream);
        else checks_passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks_total++;
        if (rx_stream.valid !== 1'b0) $display("[TB] FAIL mid_reset_release got %b expected 0", rx_stream.valid);
        else checks_passed++;
        send_byte(8'h56, c);
        send_byte(8'h78, c);
        send_byte(8'h9A, c);
        idle(2);
        send_packet(8'h05, 8'h66, 3, 8'hA0, 1);
        idle(3);
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL mid_reset_drain got %0d pending expected 0", sb.size());
        else checks_passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_garbage();
        test_zero_length();
        test_back_to_back();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_packet();
        idle(2);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/uart_packet_deframer.md
UART_PACKET_DEFRAMER -- requirements
Module: uart_packet_deframer

Interface
REQ-001 SHALL provide parameter SYNC_BYTE, default 8'h55, meaning the byte that marks the start of every packet header.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 5000, meaning the inter-byte timeout in ipClk cycles while a packet is in progress.
REQ-003 SHALL have port ipClk, input, 1, system clock; all logic is rising-edge.
REQ-004 SHALL have port ipReset, input, 1; the reset is ipReset, asynchronous, active-low.
REQ-005 SHALL have port ipRxData, input, 8, byte from the UART receiver.
REQ-006 SHALL have port ipRxValid, input, 1, one-cycle strobe qualifying ipRxData.
REQ-007 SHALL have port opRxStream, output, UART_PACKET (Source 8, Destination 8, Length 8, SoP, EoP, Data 8, Valid), the deframed packet stream.
REQ-008 SHALL have port opError, output, 1, one-cycle pulse on timeout abort.

Function
REQ-009 SHALL decode the wire format SYNC_BYTE, Destination, Source, Length, then Length data bytes.
REQ-010 SHALL implement states IDLE, DEST, SRC, LEN, DATA.
REQ-011 IDLE: a valid byte equal to SYNC_BYTE -> DEST; any other valid byte is discarded and the block stays in IDLE.
REQ-012 DEST/SRC: a valid byte latches Destination/Source and advances to SRC/LEN respectively.
REQ-013 LEN: a valid byte latches Length and loads the remaining-byte counter; Length != 0 -> DATA; Length == 0 -> IDLE with no output emitted.
REQ-014 DATA: each valid byte produces exactly one output beat, with Data = byte, Destination/Source/Length = latched header, SoP = first data byte, and EoP = last data byte (counter == 1).
REQ-015 After the EoP beat, the block SHALL return to IDLE; SYNC_BYTE values inside DATA are payload, not resync.
REQ-016 Latency: a data byte strobed at cycle N SHALL appear with opRxStream.Valid = 1 at cycle N+1, with all opRxStream fields registered.
REQ-017 opRxStream.Valid SHALL be high for exactly one cycle per data byte and never high in two consecutive cycles unless ipRxValid was high in two consecutive cycles.
REQ-018 Fields of opRxStream other than Valid SHALL hold their last value while Valid = 0.
REQ-019 Length 1 SHALL produce a single beat with SoP = EoP = 1; Length 255 SHALL produce 255 beats with no counter wrap.
REQ-020 The timeout counter SHALL clear on every ipRxValid and while in IDLE, and increment every cycle otherwise.
REQ-021 In any non-IDLE state, when the counter reaches TIMEOUT_CYCLES, the block SHALL enter IDLE and pulse opError for one cycle; no EoP is emitted for the truncated packet.
REQ-022 If ipRxValid coincides with the timeout cycle, the byte SHALL win: the counter clears, the byte is processed, and no opError is raised.
REQ-023 The block SHALL have no backpressure; downstream SHALL accept every beat.

Reset
REQ-024 Asserting ipReset (low) SHALL immediately force IDLE, clear the counters, and set opRxStream.Valid, SoP, EoP, opError, and all opRxStream fields to 0.
REQ-025 Reset mid-packet SHALL discard the packet; after release, the block SHALL wait for a fresh SYNC_BYTE.
REQ-026 No output beat SHALL be produced in the first cycle after reset release.

Verification
REQ-027 Bytes 55 01 AA 05 12 17 1C 21 26 -> five beats, Dest = 01, Src = AA, Len = 05, Data 12..26, SoP on 12, EoP on 26, each beat one cycle after its byte.
REQ-028 Bytes 00 FF 55 00 AA 01 12 -> leading garbage ignored, then one beat with Data = 12 and SoP = EoP = 1.
REQ-029 Bytes 55 00 AA 00 followed by 55 02 AA 01 34 -> first packet produces no output; second produces one beat with Dest = 02 and Data = 34.
REQ-030 Bytes 55 01 AA 03 12, then silence for TIMEOUT_CYCLES -> one beat with SoP, no EoP, one opError pulse, then IDLE; a following valid packet decodes normally.
REQ-031 A byte strobed exactly on the timeout cycle -> no opError, and the byte is accepted as data.
REQ-032 ipReset asserted after 2 of 5 data bytes, then released, then a full packet sent -> outputs 0 during reset, and only the new packet's beats appear.
